// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory port, redirect request from execute and the decode handshake.
// master = fetch unit, slave = surrounding pipeline / memory.
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              enable;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_instr;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        input  enable, imem_instr, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc
    );

    modport slave (
        output enable, imem_instr, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, reads combinational imem, buffers {pc, instr} for decode.
// One cycle PC-to-output; stalls (PC held) when the buffer is full and decode is not popping.
module inst_fetch_unit #(
    parameter int                 ADDR_W     = 8,
    parameter int                 DATA_W     = 32,
    parameter logic [ADDR_W-1:0]  PC_RESET   = '0,
    parameter int                 FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_fetch_unit_if.master     bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              pop, push;
    logic [PTR_W-1:0]  head_idx;
    entry_t            head;
    logic              unused_ok;

    assign unused_ok = ^bus.redirect_pc[1:0];

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (state_q != ST_EMPTY);

    // When empty, point one slot back so the last delivered entry stays on the outputs.
    assign head_idx      = (state_q == ST_EMPTY) ? rd_ptr_q - PTR_W'(1) : rd_ptr_q;
    assign head          = mem_q[head_idx];
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.enable & ~bus.redirect_valid & ((state_q != ST_FULL) | pop);

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            rd_ptr_d = rd_ptr_q + PTR_W'(bus.out_valid);
            wr_ptr_d = rd_ptr_d;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: pc_q, instr: bus.imem_instr};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
                pc_d            = pc_q + ADDR_W'(4);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d = ST_PARTIAL;
        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == CNT_W'(FIFO_DEPTH)) begin
            state_d = ST_FULL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            mem_q    <= mem_d;
        end
    end
endmodule
